// File: rtl/stopwatch_lap_timer_pkg.sv
// Shared constants and status encoding for the stopwatch / lap timer.
package stopwatch_lap_timer_pkg;

    localparam int unsigned SEC_WIDTH = 6;
    localparam logic [SEC_WIDTH-1:0] SEC_MAX = 6'd59;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUNNING = 2'b01,
        ST_PAUSED  = 2'b10,
        ST_EXPIRED = 2'b11
    } sw_status_e;

    // Out-of-range preload seconds saturate at 59.
    function automatic logic [SEC_WIDTH-1:0] clamp_sec(input logic [SEC_WIDTH-1:0] s);
        return (s > SEC_MAX) ? SEC_MAX : s;
    endfunction

endpackage

// File: rtl/stopwatch_lap_timer_if.sv
// Command / display bundle between the stopwatch controller and its user.
interface stopwatch_lap_timer_if #(
    parameter int unsigned MIN_WIDTH = 8,
    parameter int unsigned LAP_DEPTH = 4
);
    import stopwatch_lap_timer_pkg::*;

    localparam int unsigned CNT_WIDTH = $clog2(LAP_DEPTH + 1);

    logic                 start;
    logic                 stop;
    logic                 clear;
    logic                 mode_down;
    logic                 load;
    logic [MIN_WIDTH-1:0] load_min;
    logic [SEC_WIDTH-1:0] load_sec;
    logic                 lap;
    logic                 lap_pop;

    logic [MIN_WIDTH-1:0] minutes;
    logic [SEC_WIDTH-1:0] seconds;
    logic [1:0]           status;
    logic                 expired;
    logic                 lap_valid;
    logic [MIN_WIDTH-1:0] lap_min;
    logic [SEC_WIDTH-1:0] lap_sec;
    logic [CNT_WIDTH-1:0] lap_count;
    logic                 lap_overflow;

    modport master (
        output start, stop, clear, mode_down, load, load_min, load_sec, lap, lap_pop,
        input  minutes, seconds, status, expired, lap_valid, lap_min, lap_sec, lap_count,
               lap_overflow
    );

    modport slave (
        input  start, stop, clear, mode_down, load, load_min, load_sec, lap, lap_pop,
        output minutes, seconds, status, expired, lap_valid, lap_min, lap_sec, lap_count,
               lap_overflow
    );

endinterface

// File: rtl/stopwatch_lap_timer_lap_fifo.sv
// First-word fall-through FIFO holding captured lap times.
module lap_fifo #(
    parameter int unsigned WIDTH = 14,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear_i,
    input  logic                           push_i,
    input  logic                           pop_i,
    input  logic [WIDTH-1:0]               data_i,
    output logic [WIDTH-1:0]               data_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is only accepted when a pop frees a slot that cycle.
    always_comb begin
        pop_ok   = pop_i && !empty_o;
        push_ok  = push_i && (!full_o || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Pointer, occupancy and storage registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_ok && !clear_i) mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/stopwatch_lap_timer.sv
// Stopwatch controller: run/pause/expire FSM, tick prescaler, min:sec counters, lap capture.
module stopwatch_lap_timer
    import stopwatch_lap_timer_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 1,
    parameter int unsigned MIN_WIDTH = 8,
    parameter int unsigned LAP_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    stopwatch_lap_timer_if.slave  bus
);
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned LW = MIN_WIDTH + SEC_WIDTH;

    sw_status_e           state_q, state_d;
    logic [MIN_WIDTH-1:0] min_q, min_d;
    logic [SEC_WIDTH-1:0] sec_q, sec_d;
    logic [PW-1:0]        presc_q, presc_d;
    logic                 mode_down_q, mode_down_d;
    logic                 expired_q, expired_d;
    logic                 overflow_q, overflow_d;
    logic                 lap_push, fifo_full, fifo_empty;
    logic [LW-1:0]        fifo_head;

    assign lap_push = bus.lap && !bus.clear &&
                      ((state_q == ST_RUNNING) || (state_q == ST_PAUSED));

    // Next state for FSM, prescaler and counters; only the highest-priority command acts.
    always_comb begin
        state_d     = state_q;
        min_d       = min_q;
        sec_d       = sec_q;
        presc_d     = presc_q;
        mode_down_d = mode_down_q;
        expired_d   = 1'b0;
        if (bus.clear) begin
            state_d     = ST_IDLE;
            min_d       = '0;
            sec_d       = '0;
            presc_d     = '0;
            mode_down_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_PAUSED: begin
                    if (!bus.stop) begin
                        if (bus.start) begin
                            if (state_q == ST_PAUSED) begin
                                state_d = ST_RUNNING;
                            end else if (!(bus.mode_down && min_q == '0 && sec_q == '0)) begin
                                state_d     = ST_RUNNING;
                                mode_down_d = bus.mode_down;
                            end
                        end else if (bus.load) begin
                            min_d = bus.load_min;
                            sec_d = clamp_sec(bus.load_sec);
                        end
                    end
                end
                ST_RUNNING: begin
                    if (bus.stop) begin
                        state_d = ST_PAUSED;
                    end else if (presc_q == PW'(TICK_DIV - 1)) begin
                        presc_d = '0;
                        if (mode_down_q) begin
                            if (sec_q == '0) begin
                                sec_d = SEC_MAX;
                                min_d = min_q - 1'b1;
                            end else begin
                                sec_d = sec_q - 1'b1;
                            end
                            if (min_d == '0 && sec_d == '0) begin
                                state_d   = ST_EXPIRED;
                                expired_d = 1'b1;
                            end
                        end else if (sec_q == SEC_MAX) begin
                            sec_d = '0;
                            min_d = min_q + 1'b1;
                        end else begin
                            sec_d = sec_q + 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                ST_EXPIRED: ;
                default: state_d = ST_IDLE;
            endcase
        end
        overflow_d = bus.clear ? 1'b0
                   : (overflow_q || (lap_push && fifo_full && !bus.lap_pop));
    end

    // Controller state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            min_q       <= '0;
            sec_q       <= '0;
            presc_q     <= '0;
            mode_down_q <= 1'b0;
            expired_q   <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            presc_q     <= presc_d;
            mode_down_q <= mode_down_d;
            expired_q   <= expired_d;
            overflow_q  <= overflow_d;
        end
    end

    lap_fifo #(
        .WIDTH (LW),
        .DEPTH (LAP_DEPTH)
    ) u_lap_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear_i (bus.clear),
        .push_i  (lap_push),
        .pop_i   (bus.lap_pop),
        .data_i  ({min_q, sec_q}),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (bus.lap_count)
    );

    assign bus.minutes      = min_q;
    assign bus.seconds      = sec_q;
    assign bus.status       = state_q;
    assign bus.expired      = expired_q;
    assign bus.lap_valid    = !fifo_empty;
    assign bus.lap_min      = fifo_head[LW-1:SEC_WIDTH];
    assign bus.lap_sec      = fifo_head[SEC_WIDTH-1:0];
    assign bus.lap_overflow = overflow_q;

endmodule
